// File: rtl/dot_matrix_scheduler.sv
// Double-buffered 8x8 LED dot-matrix row scanner.
// Back-buffer swaps happen only at frame boundaries so a frame is never torn.
module dot_matrix_scheduler #(
  parameter int unsigned SCAN_DIV  = 5000,
  parameter int unsigned BLANK_CYC = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [2:0] load_row,
  input  logic [7:0] load_data,
  input  logic       swap_req,
  output logic       swap_ack,
  output logic [7:0] dot_row,
  output logic [7:0] dot_col,
  output logic       frame_done
);

  localparam logic [15:0] CntMax   = 16'(SCAN_DIV - 1);
  localparam logic [15:0] BlankCyc = 16'(BLANK_CYC);

  typedef enum logic {StIdle, StScan} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  row_q, row_d;
  logic        sel_q, sel_d;
  logic        pend_q, pend_d;
  logic [7:0]  buf_q [2][8];
  logic [7:0]  dot_row_q, dot_row_d;
  logic [7:0]  dot_col_q, dot_col_d;
  logic        load_we;

  assign load_ready = ~pend_q;
  assign load_we    = load_valid & load_ready;
  assign dot_row    = dot_row_q;
  assign dot_col    = dot_col_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    row_d      = row_q;
    sel_d      = sel_q;
    frame_done = 1'b0;
    swap_ack   = 1'b0;
    dot_row_d  = 8'hFF;
    dot_col_d  = 8'h00;
    unique case (state_q)
      StIdle: begin
        cnt_d    = 16'd0;
        row_d    = 3'd0;
        swap_ack = pend_q;
        if (pend_q) begin
          state_d = StScan;
          sel_d   = ~sel_q;
        end
      end
      StScan: begin
        if (cnt_q == CntMax) begin
          cnt_d = 16'd0;
          row_d = row_q + 3'd1;
          if (row_q == 3'd7) begin
            frame_done = 1'b1;
            swap_ack   = pend_q;
            if (pend_q) sel_d = ~sel_q;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
        // Leading cycles of each dwell stay dark to suppress ghosting.
        if (cnt_q >= BlankCyc) begin
          dot_row_d = ~(8'h80 >> row_q);
          dot_col_d = buf_q[sel_q][row_q];
        end
      end
      default: state_d = StIdle;
    endcase
    // A request seen while one is already pending is absorbed.
    pend_d = pend_q ? ~swap_ack : swap_req;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= 16'd0;
      row_q     <= 3'd0;
      sel_q     <= 1'b0;
      pend_q    <= 1'b0;
      dot_row_q <= 8'hFF;
      dot_col_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      sel_q     <= sel_d;
      pend_q    <= pend_d;
      dot_row_q <= dot_row_d;
      dot_col_q <= dot_col_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 8; r++) begin
          buf_q[b][r] <= 8'h00;
        end
      end
    end else if (load_we) begin
      buf_q[~sel_q][load_row] <= load_data;
    end
  end

endmodule

// File: doc/dot_matrix_scheduler.md
DOT_MATRIX_SCHEDULER -- requirements
Module: dot_matrix_scheduler

Interface
REQ-001 Parameter SCAN_DIV, default 5000, clk cycles each row is held (dwell); legal range 2..65535.
REQ-002 Parameter BLANK_CYC, default 1, blanking cycles at the start of each dwell; legal range 0..SCAN_DIV-1.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 load_valid  input  1  writer presents one back-buffer row this cycle.
REQ-006 load_ready  output  1  scheduler accepts a row this cycle.
REQ-007 load_row  input  3  back-buffer row index to write.
REQ-008 load_data  input  8  column pattern for that row; bit=1 lights the LED.
REQ-009 swap_req  input  1  single-cycle pulse requesting a front/back buffer swap.
REQ-010 swap_ack  output  1  one-cycle pulse when the swap takes effect.
REQ-011 dot_row  output  8  active-low one-hot row select; row 0 = 8'b01111111, row 7 = 8'b11111110.
REQ-012 dot_col  output  8  active-high column drive for the selected row.
REQ-013 frame_done  output  1  one-cycle pulse at the end of row 7's dwell.

Function
REQ-014 Two 8x8 buffers, front (displayed) and back (written); a select bit chooses which is front.
REQ-015 A load is accepted when load_valid && load_ready; load_data goes to back[load_row] on that edge.
REQ-016 load_ready = 0 while a swap is pending (swap_req seen, swap_ack not yet issued), otherwise 1.
REQ-017 A swap_req arriving while a swap is already pending is absorbed; only one swap_ack results.
REQ-018 States: IDLE (after reset, nothing displayed) and SCAN.
REQ-019 IDLE: dot_row = 8'hFF, dot_col = 8'h00, counters held at 0; a pending swap completes on the next cycle with swap_ack, then goes to SCAN at row 0, cnt 0.
REQ-020 SCAN: dwell counter cnt runs 0..SCAN_DIV-1 and wraps to 0. On wrap, row_idx increments, wrapping from 7 to 0.
REQ-021 When cnt = SCAN_DIV-1 and row_idx = 7: frame_done pulses that cycle. If a swap is pending, the select bit toggles and swap_ack pulses on the same cycle.
REQ-022 A swap never occurs mid-frame; front-buffer contents are constant from row 0 to row 7 of every displayed frame.
REQ-023 A swap_req arriving on the same cycle as the frame-end swap point is not taken for that frame; it waits for the next frame end.
REQ-024 Load and swap_req on the same cycle: the load is accepted (ready was 1) and the swap becomes pending the next cycle.
REQ-025 dot_row/dot_col are registered, one-cycle latency from (row_idx, cnt).
REQ-026 When cnt < BLANK_CYC: dot_row = 8'hFF and dot_col = 8'h00 (anti-ghosting).
REQ-027 Otherwise: dot_row = ~(8'b10000000 >> row_idx) and dot_col = front[row_idx].
REQ-028 Counter widths: cnt is 16 bits and row_idx is 3 bits. No other arithmetic is present.

Reset
REQ-029 reset low asynchronously forces all of the following: state IDLE, cnt 0, row_idx 0, select 0, swap pending 0, both buffers all-zero, dot_row 8'hFF, dot_col 8'h00, swap_ack 0, frame_done 0, load_ready 1.
REQ-030 Reset asserted mid-frame or mid-swap aborts immediately. No swap_ack or frame_done is issued for the aborted operation.
REQ-031 Release is sampled on a rising clk edge; the first accepted load can occur on the first edge after release.

Verification (SCAN_DIV=4, BLANK_CYC=1)
REQ-032 Load rows 0..7 with 8'h01<<r, then pulse swap_req -> swap_ack one cycle later. Then dot_row cycles 7F,BF,...,FE, each preceded by one FF/00 blank cycle, with dot_col = 01,02,...,80.
REQ-033 swap_req mid-frame at row 3 -> load_ready=0 until the frame_done cycle; swap_ack coincides with frame_done; the new pattern first appears at row 0.
REQ-034 Two swap_req pulses 2 cycles apart inside one frame -> exactly one swap_ack.
REQ-035 swap_req on the exact frame-end cycle -> no swap that frame; swap_ack at the following frame end (32 cycles later).
REQ-036 load_valid with load_row=5, data 8'hA5 plus swap_req on the same cycle -> after the swap, row 5 shows dot_col = A5.
REQ-037 reset pulsed low at row 4 with a swap pending -> outputs immediately FF/00, no swap_ack; after release, load_ready=1 and the scheduler is in IDLE.
